// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge detector for the RGB video pipe.
// Three pipeline stages (luma + window, gradients, magnitude/threshold) share
// one advance enable, so a stalled output freezes the whole pipe and upstream
// sees backpressure through ready_out. Two line buffers hold the luma of the
// previous two lines; the window's bottom-right tap is the current pixel.
module sobel_stream_filter #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int CW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [CW+4:0]     threshold,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              startofpacket_in,
    input  logic              endofpacket_in,
    input  logic [3*CW-1:0]   data_in,
    input  logic              ready_in,
    output logic              valid_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic [3*CW-1:0]   data_out,
    output logic              frame_err
);

    localparam int PW = 3 * CW;
    localparam int YW = CW + 2;
    localparam int GW = CW + 5;
    localparam int XW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic advance;
    logic accept;

    assign advance   = ready_in || !valid_out;
    assign ready_out = advance;
    assign accept    = valid_in && advance;

    // ---------------------------------------------------------------
    // Position tracking and per-frame latched settings
    // ---------------------------------------------------------------
    logic [XW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [XW-1:0] col_eff;
    logic [RW-1:0] row_eff;
    logic          synced;
    logic [1:0]    mode_lat;
    logic [GW-1:0] thr_lat;
    logic [1:0]    mode_eff;
    logic [GW-1:0] thr_eff;
    logic          at_last;
    logic          cnt_zero;
    logic          bad_sop;
    logic          bad_eop;

    // An sop pins its own pixel to (0,0) and brings in fresh settings.
    assign col_eff  = startofpacket_in ? '0 : col_cnt;
    assign row_eff  = startofpacket_in ? '0 : row_cnt;
    assign mode_eff = startofpacket_in ? mode : mode_lat;
    assign thr_eff  = startofpacket_in ? threshold : thr_lat;

    // Until the first sop after reset the stream position is unknown, so
    // leftovers of an interrupted frame must not raise frame_err.
    assign at_last  = (col_eff == COL_LAST) && (row_eff == ROW_LAST);
    assign cnt_zero = (col_cnt == '0) && (row_cnt == '0);
    assign bad_sop  = startofpacket_in && synced && !cnt_zero;
    assign bad_eop  = endofpacket_in && (synced || startofpacket_in) && !at_last;

    // Counters, sync flag, latched mode/threshold and sticky frame error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            synced    <= 1'b0;
            mode_lat  <= '0;
            thr_lat   <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            if (endofpacket_in) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (col_eff == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= (row_eff == ROW_LAST) ? row_eff : row_eff + RW'(1);
            end else begin
                col_cnt <= col_eff + XW'(1);
                row_cnt <= row_eff;
            end
            if (startofpacket_in) begin
                synced   <= 1'b1;
                mode_lat <= mode;
                thr_lat  <= threshold;
            end
            if (bad_sop || bad_eop) begin
                frame_err <= 1'b1;
            end else if (startofpacket_in) begin
                frame_err <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Luma and line buffers
    // ---------------------------------------------------------------
    logic [CW-1:0] r_in;
    logic [CW-1:0] g_in;
    logic [CW-1:0] b_in;
    logic [YW-1:0] y_cur;
    logic [YW-1:0] lb_up1 [IMG_W];
    logic [YW-1:0] lb_up2 [IMG_W];
    logic [YW-1:0] up1_rd;
    logic [YW-1:0] up2_rd;

    assign r_in   = data_in[3*CW-1:2*CW];
    assign g_in   = data_in[2*CW-1:CW];
    assign b_in   = data_in[CW-1:0];
    assign y_cur  = {2'b00, r_in} + {1'b0, g_in, 1'b0} + {2'b00, b_in};
    assign up1_rd = lb_up1[col_eff];
    assign up2_rd = lb_up2[col_eff];

    // Line-buffer RAM: the one-line-up word ages into the two-lines-up buffer.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_up2[col_eff] <= up1_rd;
            lb_up1[col_eff] <= y_cur;
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: 3x3 luma window plus side-band
    // ---------------------------------------------------------------
    logic          v1;
    logic          sop1;
    logic          eop1;
    logic          bord1;
    logic [1:0]    mode1;
    logic [GW-1:0] thr1;
    logic [PW-1:0] dat1;
    logic [YW-1:0] win [3][3];

    // Window shifts left on each accepted beat; the new column enters at c=2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sop1  <= 1'b0;
            eop1  <= 1'b0;
            bord1 <= 1'b1;
            mode1 <= '0;
            thr1  <= '0;
            dat1  <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (advance) begin
            v1 <= accept;
            if (accept) begin
                sop1  <= startofpacket_in;
                eop1  <= endofpacket_in;
                bord1 <= (col_eff < XW'(2)) || (row_eff < RW'(2));
                mode1 <= mode_eff;
                thr1  <= thr_eff;
                dat1  <= data_in;
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= up2_rd;
                win[1][2] <= up1_rd;
                win[2][2] <= y_cur;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: gradients
    // ---------------------------------------------------------------
    function automatic logic signed [GW-1:0] tap_sum(input logic [YW-1:0] a,
                                                     input logic [YW-1:0] b,
                                                     input logic [YW-1:0] c);
        return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
    endfunction

    logic signed [GW-1:0] gx_c;
    logic signed [GW-1:0] gy_c;
    logic                 v2;
    logic                 sop2;
    logic                 eop2;
    logic                 bord2;
    logic [1:0]           mode2;
    logic [GW-1:0]        thr2;
    logic [PW-1:0]        dat2;
    logic signed [GW-1:0] gx2;
    logic signed [GW-1:0] gy2;

    assign gx_c = tap_sum(win[0][2], win[1][2], win[2][2]) - tap_sum(win[0][0], win[1][0], win[2][0]);
    assign gy_c = tap_sum(win[2][0], win[2][1], win[2][2]) - tap_sum(win[0][0], win[0][1], win[0][2]);

    // Register gradients and carry side-band one stage further.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sop2  <= 1'b0;
            eop2  <= 1'b0;
            bord2 <= 1'b1;
            mode2 <= '0;
            thr2  <= '0;
            dat2  <= '0;
            gx2   <= '0;
            gy2   <= '0;
        end else if (advance) begin
            v2    <= v1;
            sop2  <= sop1;
            eop2  <= eop1;
            bord2 <= bord1;
            mode2 <= mode1;
            thr2  <= thr1;
            dat2  <= dat1;
            gx2   <= gx_c;
            gy2   <= gy_c;
        end
    end

    // ---------------------------------------------------------------
    // Stage 3: magnitude, threshold, output register
    // ---------------------------------------------------------------
    logic [GW-1:0] gx_u;
    logic [GW-1:0] gy_u;
    logic [GW-1:0] ax;
    logic [GW-1:0] ay;
    logic [GW:0]   sum_xy;
    logic [GW-1:0] mag;
    logic [PW-1:0] dout_c;

    assign gx_u   = gx2;
    assign gy_u   = gy2;
    assign ax     = gx_u[GW-1] ? (~gx_u + GW'(1)) : gx_u;
    assign ay     = gy_u[GW-1] ? (~gy_u + GW'(1)) : gy_u;
    assign sum_xy = {1'b0, ax} + {1'b0, ay};

    // Pick the magnitude for the latched mode and form the output pixel.
    always_comb begin
        mag = '0;
        case (mode2)
            2'd1:    mag = ay;
            2'd2:    mag = ax;
            2'd3:    mag = sum_xy[GW] ? '1 : sum_xy[GW-1:0];
            default: mag = '0;
        endcase
        dout_c = '0;
        if (mode2 == 2'd0) begin
            dout_c = dat2;
        end else if (!bord2 && (mag > thr2)) begin
            dout_c = '1;
        end
    end

    // Output register; held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out         <= 1'b0;
            startofpacket_out <= 1'b0;
            endofpacket_out   <= 1'b0;
            data_out          <= '0;
        end else if (advance) begin
            valid_out         <= v2;
            startofpacket_out <= v2 && sop2;
            endofpacket_out   <= v2 && eop2;
            data_out          <= dout_c;
        end
    end

endmodule
